// File: rtl/regfile_dump_pkg.sv
// rtl/regfile_dump_pkg.sv - shared state encoding and widths for the register dump engine
package regfile_dump_pkg;
  localparam int IDX_W = 5;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/regfile_dump_shadow.sv
// rtl/regfile_dump_shadow.sv - baseline copy of the last values emitted per register
module dump_shadow
  import regfile_dump_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DW       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [DW-1:0]    wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [DW-1:0]    rdata
);
  logic [DW-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];
endmodule

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - walks the register file read port and streams {index, value} beats
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DW       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             changed_only,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] dump_count,
  output logic [IDX_W-1:0] rf_addr,
  input  logic [DW-1:0]    rf_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [IDX_W-1:0] dump_index,
  output logic [DW-1:0]    dump_data
);
  state_t           r_state, w_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_mode;
  logic             r_snap_valid;
  logic [CNT_W-1:0] r_count;
  logic [IDX_W-1:0] r_dump_index;
  logic [DW-1:0]    r_dump_data;
  logic [DW-1:0]    w_shadow_rdata;
  logic             w_last, w_skip, w_hs;

  assign w_last = (r_idx == IDX_W'(NUM_REGS - 1));
  assign w_skip = r_mode && r_snap_valid && (rf_data == w_shadow_rdata);
  assign w_hs   = (r_state == ST_SEND) && dump_ready;

  // Shadow is refreshed with whatever the sink actually accepted.
  dump_shadow #(.NUM_REGS(NUM_REGS), .DW(DW)) u_shadow (
    .clk   (clk),
    .reset (reset),
    .we    (w_hs),
    .waddr (r_idx),
    .wdata (r_dump_data),
    .raddr (r_idx),
    .rdata (w_shadow_rdata)
  );

  always_comb begin
    w_next     = r_state;
    busy       = (r_state != ST_IDLE);
    done       = 1'b0;
    dump_valid = 1'b0;
    rf_addr    = '0;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_READ;
      ST_READ: begin
        rf_addr = r_idx;
        if (!w_skip)     w_next = ST_SEND;
        else if (w_last) w_next = ST_DONE;
      end
      ST_SEND: begin
        dump_valid = 1'b1;
        if (dump_ready) w_next = w_last ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx        <= '0;
      r_mode       <= 1'b0;
      r_snap_valid <= 1'b0;
      r_count      <= '0;
      r_dump_index <= '0;
      r_dump_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx   <= '0;
            r_mode  <= changed_only;
            r_count <= '0;
          end
        end
        ST_READ: begin
          r_dump_index <= r_idx;
          r_dump_data  <= rf_data;
          if (w_skip && !w_last) r_idx <= r_idx + 1'b1;
        end
        ST_SEND: begin
          if (dump_ready) begin
            r_count <= r_count + 1'b1;
            if (!w_last) r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          // Only a full dump leaves a complete baseline behind.
          if (!r_mode) r_snap_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dump_count = r_count;
  assign dump_index = r_dump_index;
  assign dump_data  = r_dump_data;
endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - directed-vector bench for regfile_dump
module tb_regfile_dump;
  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        reset, start, changed_only, dump_ready;
  logic        busy, done, dump_valid;
  logic [5:0]  dump_count;
  logic [4:0]  rf_addr, dump_index;
  logic [31:0] rf_data, dump_data;
  logic [31:0] rf [NR];

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  int          q_idx[$];
  logic [31:0] q_data[$];
  int          first_valid, done_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rf_data = rf[rf_addr];

  regfile_dump #(.NUM_REGS(NR), .DW(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .changed_only (changed_only),
    .busy         (busy),
    .done         (done),
    .dump_count   (dump_count),
    .rf_addr      (rf_addr),
    .rf_data      (rf_data),
    .dump_valid   (dump_valid),
    .dump_ready   (dump_ready),
    .dump_index   (dump_index),
    .dump_data    (dump_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_valid"}, dump_valid, 0);
    chk({tag, "_index"}, dump_index, 0);
    chk({tag, "_data"},  dump_data, 0);
    chk({tag, "_count"}, dump_count, 0);
    chk({tag, "_addr"},  rf_addr, 0);
  endtask

  // Runs one dump from the current cycle (cycle 0). Stops on done, or after
  // abort_at accepted beats by pulsing reset for one edge.
  task automatic do_dump(input logic mode, input int stall, input int poke, input int abort_at);
    int          c0, waited, nb;
    logic [4:0]  hold_i;
    logic [31:0] hold_d;
    bit          stop, in_beat;
    q_idx.delete();
    q_data.delete();
    first_valid = -1;
    done_cyc    = -1;
    c0 = cyc; waited = 0; nb = 0; stop = 0; in_beat = 0;
    hold_i = '0; hold_d = '0;
    start = 1'b1; changed_only = mode; dump_ready = (stall == 0);
    tick;
    start = 1'b0; changed_only = ~mode;
    for (int k = 0; k < 400 && !stop; k++) begin
      start = (cyc - c0 == poke);
      if (done) begin
        stop = 1; done_cyc = cyc - c0;
      end else begin
        if (dump_valid) begin
          if (first_valid < 0) first_valid = cyc - c0;
          if (!in_beat) begin
            hold_i = dump_index; hold_d = dump_data; in_beat = 1; waited = 0;
          end else begin
            chk("stall_index", dump_index, hold_i);
            chk("stall_data",  dump_data,  hold_d);
          end
          if (waited == stall) begin
            dump_ready = 1'b1;
            q_idx.push_back(int'(dump_index));
            q_data.push_back(dump_data);
            in_beat = 0;
            nb++;
          end else begin
            dump_ready = 1'b0;
            waited++;
          end
        end else begin
          dump_ready = (stall == 0);
        end
        if (abort_at > 0 && nb == abort_at) begin
          tick;
          reset = 1'b1; dump_ready = 1'b0;
          tick;
          reset = 1'b0;
          stop = 1;
        end else begin
          tick;
        end
      end
    end
    start = 1'b0;
    if (!stop) chk("dump_timeout", 0, 1);
  endtask

  task automatic chk_all_beats(input string tag);
    chk({tag, "_nbeats"}, q_idx.size(), NR);
    for (int i = 0; i < NR; i++) begin
      if (i < q_idx.size()) begin
        chk({tag, "_idx"},  q_idx[i],  i);
        chk({tag, "_data"}, q_data[i], rf[i]);
      end
    end
  endtask

  task automatic chk_end(input string tag, input int exp_done, input int exp_count);
    chk({tag, "_done_cyc"}, done_cyc, exp_done);
    chk({tag, "_count"}, dump_count, exp_count);
    tick;
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_count_held"}, dump_count, exp_count);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; changed_only = 1'b0; dump_ready = 1'b0;
    for (int i = 0; i < NR; i++) rf[i] = 32'h100 + i;
    tick; tick;
    chk_reset_state("reset");
    reset = 1'b0;
    tick;

    // Full dump, ready always high; next start lands at cycle 66.
    do_dump(1'b0, 0, -1, 0);
    chk_all_beats("full");
    chk("full_first_valid", first_valid, 2);
    chk_end("full", 65, 32);

    rf[5]  = 32'hDEADBEEF;
    rf[31] = 32'h0000_0001;
    do_dump(1'b1, 0, -1, 0);
    chk("chg_nbeats", q_idx.size(), 2);
    if (q_idx.size() == 2) begin
      chk("chg_idx0",  q_idx[0],  5);
      chk("chg_data0", q_data[0], 32'hDEADBEEF);
      chk("chg_idx1",  q_idx[1],  31);
      chk("chg_data1", q_data[1], 32'h1);
    end
    chk("chg_first_valid", first_valid, 7);
    chk_end("chg", 35, 2);

    do_dump(1'b1, 0, -1, 0);
    chk("none_nbeats", q_idx.size(), 0);
    chk("none_first_valid", first_valid, -1);
    chk_end("none", 33, 0);

    do_dump(1'b0, 3, -1, 0);
    chk_all_beats("bp");
    chk("bp_first_valid", first_valid, 2);
    chk_end("bp", 161, 32);

    // Reset after the tenth beat clears the baseline.
    do_dump(1'b0, 0, -1, 10);
    chk("abort_nbeats", q_idx.size(), 10);
    chk_reset_state("abort");
    do_dump(1'b1, 0, -1, 0);
    chk_all_beats("post_rst");
    chk_end("post_rst", 65, 32);
    do_dump(1'b1, 0, -1, 0);
    chk_all_beats("post_rst2");
    chk_end("post_rst2", 65, 32);

    do_dump(1'b0, 0, 20, 0);
    chk_all_beats("poke");
    chk_end("poke", 65, 32);
    tick;
    chk("poke_no_queue", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the single-cycle CPU register file. On a start pulse it walks the register file's read port from register 0 upward and streams every register, or only those changed since the previous dump, as `{index, value}` beats on a valid/ready interface. It sits beside the datapath and is the hardware counterpart of the bench's register dump, so a host or monitor can collect architectural state at run time.

## Interface
Parameters:
- `NUM_REGS`, default 32: registers scanned, indices `0..NUM_REGS-1`; must be ≤ 32.
- `DW`, default 32: register data width.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: dump request; sampled only in IDLE.
- `changed_only`, input, 1: mode; latched when `start` is accepted.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse when a dump completes.
- `dump_count`, output, 6: beats emitted by the last dump; valid from `done`, held until the next accepted start.
- `rf_addr`, output, 5: register file read address.
- `rf_data`, input, DW: register file read data; combinational in `rf_addr` within the same cycle.
- `dump_valid`, output, 1: beat valid.
- `dump_ready`, input, 1: sink accepts the beat.
- `dump_index`, output, 5: register index of the beat.
- `dump_data`, output, DW: register value of the beat.

## Operation
- States:
  - IDLE: `rf_addr` = 0. `start` causes: `idx` ← 0, latch the mode, `dump_count` ← 0, go to READ.
  - READ: `rf_addr` = `idx`. Capture `rf_data` into the output register and set `dump_index` ← `idx`.
    - Skip when `changed_only` && `snap_valid` && `rf_data == shadow[idx]`.
    - On skip: if `idx == NUM_REGS-1` go to DONE, else `idx`+1 and stay in READ.
    - Otherwise go to SEND.
  - SEND: `dump_valid` = 1. `dump_index` and `dump_data` stay stable until `dump_ready`.
    - On handshake: `shadow[idx]` ← `dump_data`, `dump_count`+1.
    - Then, if `idx == NUM_REGS-1` go to DONE, else `idx`+1 and go to READ.
  - DONE: `done` = 1 for this cycle. Set `snap_valid` ← 1 only if the completed dump was full mode. Go to IDLE.
- `shadow` is `NUM_REGS` × `DW` of state. `snap_valid` = 0 means no baseline exists, so changed-only dumps emit every register.
- Full-mode dumps always emit all `NUM_REGS` registers and refresh the whole shadow.
- `start` while busy: ignored, with no queueing.
- `dump_valid` never depends combinationally on `dump_ready`.
- Changed-only dump with zero changes: no beats, `done` pulses, `dump_count` = 0.
- Register 0 is treated like any other register, with no special casing.

## Timing
- Reset values: `busy`=0, `done`=0, `dump_valid`=0, `dump_index`=0, `dump_data`=0, `dump_count`=0, `rf_addr`=0, `snap_valid`=0, shadow all 0, state IDLE.
- Reset asserted mid-dump: the in-flight beat is dropped, and all of the above are restored on the next edge.
- Latency with `start` at cycle 0:
  - READ at cycle 1; first `dump_valid` at cycle 2.
  - Each emitted register costs 2 cycles when `dump_ready` is held high; each skipped register costs 1 cycle.
- Full dump, NUM_REGS=32, ready always high:
  - Last handshake at cycle 64, `done` at cycle 65, IDLE at cycle 66.
  - `start` is accepted again at cycle 66.
- Backpressure: every cycle of `dump_ready`=0 in SEND adds one cycle. Payload is frozen during stall.
- Register file writes during a dump are permitted. Each register is sampled in its own READ cycle only.

## Structure
- Shared package `regfile_dump_pkg` holds:
  - the state encoding (IDLE, READ, SEND, DONE);
  - the index width constant 5;
  - the count width constant 6.
- One natural sub-module: `dump_shadow`, a `NUM_REGS`×`DW` register array.
  - One synchronous write port (`we`, `waddr`, `wdata`).
  - One combinational read port.
  - Synchronous reset to zero.
- The FSM, index counter, beat counter and output register stay in `regfile_dump`.

## Test plan
- Full dump: preload regfile with `reg[i] = 0x100+i`, pulse `start` with `changed_only`=0, ready high.
  - 32 beats: index 0..31, data 0x100..0x11F.
  - First valid at cycle 2; `done` at cycle 65; `dump_count` = 32.
- Changed-only after the full dump: set reg 5 = 0xDEADBEEF and reg 31 = 0x1.
  - Exactly 2 beats: (5, 0xDEADBEEF) then (31, 0x00000001).
  - `dump_count` = 2; shadow updated.
- Changed-only with no changes: no `dump_valid`, `done` pulses, `dump_count` = 0, total 34 cycles from `start`.
- Backpressure: full dump with `dump_ready` low 3 cycles on every beat.
  - Payload stable while stalled.
  - `done` at cycle 65 + 96 = 161.
- Reset mid-dump at beat 10, then a `changed_only` dump: all 32 registers are emitted, because `snap_valid` was cleared.
- `start` pulsed while busy at cycle 20: ignored, and the single dump completes unaffected.
